// File: rtl/trap_sequencer_pkg.sv
// Shared constants for the M-mode trap sequencer: trap codes, CSR addresses,
// cause codes, FSM state encodings and the mstatus read-modify-write helper.
package trap_sequencer_pkg;

    localparam logic [2:0] TRAP_NONE       = 3'd0;
    localparam logic [2:0] TRAP_ECALL      = 3'd1;
    localparam logic [2:0] TRAP_EBREAK     = 3'd2;
    localparam logic [2:0] TRAP_MISALIGNED = 3'd3;
    localparam logic [2:0] TRAP_FENCEI     = 3'd4;
    localparam logic [2:0] TRAP_MRET       = 3'd5;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam logic [4:0] CAUSE_MISALIGNED = 5'd0;
    localparam logic [4:0] CAUSE_EBREAK     = 5'd3;
    localparam logic [4:0] CAUSE_ECALL      = 5'd11;
    localparam logic [4:0] IRQ_MSI          = 5'd3;
    localparam logic [4:0] IRQ_MTI          = 5'd7;
    localparam logic [4:0] IRQ_MEI          = 5'd11;
    localparam logic [4:0] IRQ_PLAT_BASE    = 5'd16;

    localparam int MIP_MSI = 0;
    localparam int MIP_MTI = 1;
    localparam int MIP_MEI = 2;

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_WR_MEPC    = 4'd1;
    localparam logic [3:0] S_WR_MCAUSE  = 4'd2;
    localparam logic [3:0] S_WR_MTVAL   = 4'd3;
    localparam logic [3:0] S_RD_MSTATUS = 4'd4;
    localparam logic [3:0] S_WR_MSTATUS = 4'd5;
    localparam logic [3:0] S_RD_MTVEC   = 4'd6;
    localparam logic [3:0] S_RD_MEPC    = 4'd7;
    localparam logic [3:0] S_DONE       = 4'd8;
    localparam logic [3:0] S_FENCEI     = 4'd9;
    localparam logic [3:0] S_WAIT_CLR   = 4'd10;

    function automatic logic [4:0] exc_cause(input logic [2:0] code);
        logic [4:0] c;
        case (code)
            TRAP_ECALL:  c = CAUSE_ECALL;
            TRAP_EBREAK: c = CAUSE_EBREAK;
            default:     c = CAUSE_MISALIGNED;
        endcase
        return c;
    endfunction

    // Low mstatus bits: MIE=3, MPIE=7, MPP=12:11. Trap entry stacks MIE, MRET unstacks it.
    function automatic logic [12:0] mstatus_update(input logic [12:0] m, input logic is_mret);
        logic [12:0] r;
        r = m;
        if (is_mret) begin
            r[3] = m[7];
            r[7] = 1'b1;
        end else begin
            r[7] = m[3];
            r[3] = 1'b0;
        end
        r[12:11] = 2'b11;
        return r;
    endfunction

endpackage

// File: rtl/trap_sequencer_if.sv
// CSR-file access bus driven by the trap sequencer (master) toward the CSR file (slave).
interface trap_sequencer_if #(
    parameter int XLEN = 32
);
    logic [11:0]     csr_trap_address;
    logic            csr_trap_write_en;
    logic [XLEN-1:0] csr_trap_write_data;
    logic [XLEN-1:0] csr_read_data;

    modport master (
        output csr_trap_address, csr_trap_write_en, csr_trap_write_data,
        input  csr_read_data
    );

    modport slave (
        input  csr_trap_address, csr_trap_write_en, csr_trap_write_data,
        output csr_read_data
    );
endinterface

// File: rtl/trap_sequencer_irq_arbiter.sv
// Fixed-priority interrupt selector: MEI > MSI > MTI > plat[0] > ... > plat[n-1].
module trap_irq_arbiter
    import trap_sequencer_pkg::*;
#(
    parameter int NUM_PLAT_IRQ = 4
) (
    input  logic [NUM_PLAT_IRQ+2:0] irq_mip_i,
    output logic                    irq_valid_o,
    output logic [4:0]              irq_cause_o
);

    // Scan platform lines from highest index down so the lowest pending index wins.
    always_comb begin
        irq_valid_o = 1'b0;
        irq_cause_o = 5'd0;
        for (int i = NUM_PLAT_IRQ - 1; i >= 0; i--) begin
            irq_cause_o = irq_mip_i[3 + i] ? (IRQ_PLAT_BASE + 5'(i)) : irq_cause_o;
            irq_valid_o = irq_valid_o | irq_mip_i[3 + i];
        end
        if (irq_mip_i[MIP_MEI]) begin
            irq_valid_o = 1'b1;
            irq_cause_o = IRQ_MEI;
        end else if (irq_mip_i[MIP_MSI]) begin
            irq_valid_o = 1'b1;
            irq_cause_o = IRQ_MSI;
        end else if (irq_mip_i[MIP_MTI]) begin
            irq_valid_o = 1'b1;
            irq_cause_o = IRQ_MTI;
        end else begin
            irq_valid_o = irq_valid_o;
        end
    end

endmodule

// File: rtl/trap_sequencer.sv
// M-mode trap sequencer: walks the CSR file through exception/interrupt entry,
// MRET return and FENCE.I, then presents the redirect target to PC logic.
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int NUM_PLAT_IRQ = 4,
    parameter int VECTORED_EN  = 1,
    parameter int EBREAK_HALT  = 1,
    parameter int MRET_PLUS4   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [XLEN-1:0]         pc,
    input  logic [2:0]              trap_status,
    input  logic [XLEN-1:0]         trap_value,
    input  logic [NUM_PLAT_IRQ+2:0] irq_mip,
    input  logic                    mstatus_mie,
    trap_sequencer_if.master        csr,
    output logic [XLEN-1:0]         trap_target,
    output logic                    trap_target_valid,
    output logic                    trap_done,
    output logic                    ic_clean,
    output logic                    debug_mode,
    output logic                    irq_taken
);

    logic [3:0]      state_q, state_d;
    logic [2:0]      code_q, code_d;
    logic            irq_q, irq_d, debug_q, debug_d;
    logic [XLEN-1:0] pc_q, pc_d, cause_q, cause_d, mtval_q, mtval_d;
    logic [XLEN-1:0] mstatus_q, mstatus_d, target_q, target_d;
    logic            irq_valid_s, is_exc_s, halt_s;
    logic [4:0]      irq_cause_s;
    logic [XLEN-1:0] base_s;

    trap_irq_arbiter #(.NUM_PLAT_IRQ(NUM_PLAT_IRQ)) u_arb (
        .irq_mip_i   (irq_mip),
        .irq_valid_o (irq_valid_s),
        .irq_cause_o (irq_cause_s)
    );

    assign is_exc_s = (trap_status == TRAP_ECALL) || (trap_status == TRAP_EBREAK)
                   || (trap_status == TRAP_MISALIGNED);
    assign halt_s   = (EBREAK_HALT != 32'sd0) && (code_q == TRAP_EBREAK);
    assign base_s   = {csr.csr_read_data[XLEN-1:2], 2'b00};

    // Next-state and latched-context logic.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        irq_d     = irq_q;
        pc_d      = pc_q;
        cause_d   = cause_q;
        mtval_d   = mtval_q;
        mstatus_d = mstatus_q;
        target_d  = target_q;
        debug_d   = debug_q;
        case (state_q)
            S_IDLE: begin
                if (trap_status == TRAP_MRET) begin
                    code_d  = TRAP_MRET;
                    irq_d   = 1'b0;
                    state_d = S_RD_MSTATUS;
                end else if (is_exc_s) begin
                    code_d  = trap_status;
                    irq_d   = 1'b0;
                    pc_d    = pc;
                    cause_d = {{(XLEN-5){1'b0}}, exc_cause(trap_status)};
                    if (trap_status == TRAP_MISALIGNED) begin
                        mtval_d = trap_value;
                    end else if (trap_status == TRAP_EBREAK) begin
                        mtval_d = pc;
                    end else begin
                        mtval_d = '0;
                    end
                    state_d = S_WR_MEPC;
                end else if (trap_status == TRAP_FENCEI) begin
                    code_d  = TRAP_FENCEI;
                    state_d = S_FENCEI;
                end else if ((trap_status == TRAP_NONE) && mstatus_mie && irq_valid_s) begin
                    code_d  = TRAP_NONE;
                    irq_d   = 1'b1;
                    pc_d    = pc;
                    cause_d = {1'b1, {(XLEN-6){1'b0}}, irq_cause_s};
                    mtval_d = '0;
                    state_d = S_WR_MEPC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR_MEPC:    state_d = S_WR_MCAUSE;
            S_WR_MCAUSE:  state_d = S_WR_MTVAL;
            S_WR_MTVAL:   state_d = S_RD_MSTATUS;
            S_RD_MSTATUS: begin
                mstatus_d = csr.csr_read_data;
                state_d   = S_WR_MSTATUS;
            end
            S_WR_MSTATUS: begin
                if (code_q == TRAP_MRET) begin
                    state_d = S_RD_MEPC;
                end else if (halt_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RD_MTVEC;
                end
            end
            S_RD_MTVEC: begin
                // Only interrupts honour vectored mode; the offset wraps modulo 2^XLEN.
                if (irq_q && (VECTORED_EN != 32'sd0) && (csr.csr_read_data[1:0] == 2'b01)) begin
                    target_d = base_s + {cause_q[XLEN-3:0], 2'b00};
                end else begin
                    target_d = base_s;
                end
                state_d = S_DONE;
            end
            S_RD_MEPC: begin
                target_d = (MRET_PLUS4 != 32'sd0)
                         ? csr.csr_read_data + {{(XLEN-3){1'b0}}, 3'd4}
                         : csr.csr_read_data;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (halt_s) begin
                    debug_d = 1'b1;
                end else if (code_q == TRAP_MRET) begin
                    debug_d = 1'b0;
                end else begin
                    debug_d = debug_q;
                end
                state_d = S_WAIT_CLR;
            end
            S_FENCEI:   state_d = S_WAIT_CLR;
            S_WAIT_CLR: state_d = (trap_status == TRAP_NONE) ? S_IDLE : S_WAIT_CLR;
            default:    state_d = S_IDLE;
        endcase
    end

    // State and context registers; reset aborts any sequence in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            code_q    <= TRAP_NONE;
            irq_q     <= 1'b0;
            pc_q      <= '0;
            cause_q   <= '0;
            mtval_q   <= '0;
            mstatus_q <= '0;
            target_q  <= '0;
            debug_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            irq_q     <= irq_d;
            pc_q      <= pc_d;
            cause_q   <= cause_d;
            mtval_q   <= mtval_d;
            mstatus_q <= mstatus_d;
            target_q  <= target_d;
            debug_q   <= debug_d;
        end
    end

    // Moore output decode from the state register.
    always_comb begin
        csr.csr_trap_address    = 12'h000;
        csr.csr_trap_write_en   = 1'b0;
        csr.csr_trap_write_data = '0;
        trap_done               = 1'b0;
        case (state_q)
            S_WR_MEPC: begin
                csr.csr_trap_address    = CSR_MEPC;
                csr.csr_trap_write_en   = 1'b1;
                csr.csr_trap_write_data = pc_q;
            end
            S_WR_MCAUSE: begin
                csr.csr_trap_address    = CSR_MCAUSE;
                csr.csr_trap_write_en   = 1'b1;
                csr.csr_trap_write_data = cause_q;
            end
            S_WR_MTVAL: begin
                csr.csr_trap_address    = CSR_MTVAL;
                csr.csr_trap_write_en   = 1'b1;
                csr.csr_trap_write_data = mtval_q;
            end
            S_RD_MSTATUS: csr.csr_trap_address = CSR_MSTATUS;
            S_WR_MSTATUS: begin
                csr.csr_trap_address    = CSR_MSTATUS;
                csr.csr_trap_write_en   = 1'b1;
                csr.csr_trap_write_data = {mstatus_q[XLEN-1:13],
                                           mstatus_update(mstatus_q[12:0], code_q == TRAP_MRET)};
            end
            S_RD_MTVEC: csr.csr_trap_address = CSR_MTVEC;
            S_RD_MEPC:  csr.csr_trap_address = CSR_MEPC;
            S_IDLE, S_DONE, S_FENCEI, S_WAIT_CLR: trap_done = 1'b1;
            default: trap_done = 1'b0;
        endcase
    end

    assign trap_target       = target_q;
    assign trap_target_valid = (state_q == S_DONE) && !halt_s;
    assign irq_taken         = (state_q == S_DONE) && irq_q;
    assign ic_clean          = (state_q == S_FENCEI);
    assign debug_mode        = debug_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Randomized scoreboard bench for trap_sequencer with a small CSR-file environment.
module tb_trap_sequencer;
    import trap_sequencer_pkg::*;

    localparam int EV_WRITE = 0;
    localparam int EV_REDIR = 1;
    localparam int EV_FENCE = 2;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic        irq;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc, trap_value, trap_target;
    logic [2:0]  trap_status;
    logic [6:0]  irq_mip;
    logic        mstatus_mie;
    logic        trap_target_valid, trap_done, ic_clean, debug_mode, irq_taken;

    logic [31:0] env_ms, env_tvec, env_epc, env_cause, env_tval;
    logic        pre_en;
    logic [31:0] pre_ms, pre_tvec, pre_epc;

    logic [31:0] ref_ms, ref_tvec, ref_epc;
    logic        exp_debug;
    ev_t         exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    trap_sequencer_if #(.XLEN(32)) bus ();

    trap_sequencer #(
        .XLEN(32), .NUM_PLAT_IRQ(4), .VECTORED_EN(1), .EBREAK_HALT(1), .MRET_PLUS4(0)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .pc                (pc),
        .trap_status       (trap_status),
        .trap_value        (trap_value),
        .irq_mip           (irq_mip),
        .mstatus_mie       (mstatus_mie),
        .csr               (bus),
        .trap_target       (trap_target),
        .trap_target_valid (trap_target_valid),
        .trap_done         (trap_done),
        .ic_clean          (ic_clean),
        .debug_mode        (debug_mode),
        .irq_taken         (irq_taken)
    );

    // CSR file environment: preload from the bench, otherwise accept DUT writes.
    always @(posedge clk) begin
        if (pre_en) begin
            env_ms   <= pre_ms;
            env_tvec <= pre_tvec;
            env_epc  <= pre_epc;
        end else if (bus.csr_trap_write_en) begin
            case (bus.csr_trap_address)
                CSR_MSTATUS: env_ms    <= bus.csr_trap_write_data;
                CSR_MTVEC:   env_tvec  <= bus.csr_trap_write_data;
                CSR_MEPC:    env_epc   <= bus.csr_trap_write_data;
                CSR_MCAUSE:  env_cause <= bus.csr_trap_write_data;
                CSR_MTVAL:   env_tval  <= bus.csr_trap_write_data;
                default:     env_tval  <= env_tval;
            endcase
        end
    end

    always_comb begin
        case (bus.csr_trap_address)
            CSR_MSTATUS: bus.csr_read_data = env_ms;
            CSR_MTVEC:   bus.csr_read_data = env_tvec;
            CSR_MEPC:    bus.csr_read_data = env_epc;
            CSR_MCAUSE:  bus.csr_read_data = env_cause;
            CSR_MTVAL:   bus.csr_read_data = env_tval;
            default:     bus.csr_read_data = 32'h0;
        endcase
    end

    assign mstatus_mie = env_ms[3];

    function automatic void push(int k, logic [31:0] a, logic [31:0] d, logic i);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d; e.irq = i;
        exp_q.push_back(e);
    endfunction

    function automatic int pick_irq(logic [6:0] mip);
        int order [7];
        int cause [7];
        order = '{2, 0, 1, 3, 4, 5, 6};
        cause = '{11, 3, 7, 16, 17, 18, 19};
        for (int i = 0; i < 7; i++) if (mip[order[i]]) return cause[i];
        return -1;
    endfunction

    function automatic logic [31:0] trap_entry_ms(logic [31:0] m);
        return (m & ~32'h0000_1888) | (((m >> 3) & 32'h1) << 7) | 32'h0000_1800;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic monitor();
        ev_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (bus.csr_trap_write_en === 1'b1) begin
                    n_checks++;
                    if (exp_q.size() == 0 || exp_q[0].kind != EV_WRITE) begin
                        n_errors++;
                        $display("FAIL csr_write unexpected actual addr=%h data=%h", bus.csr_trap_address, bus.csr_trap_write_data);
                        if (exp_q.size() != 0) void'(exp_q.pop_front());
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.csr_trap_address !== e.addr[11:0] || bus.csr_trap_write_data !== e.data) begin
                            n_errors++;
                            $display("FAIL csr_write actual addr=%h data=%h required addr=%h data=%h",
                                     bus.csr_trap_address, bus.csr_trap_write_data, e.addr[11:0], e.data);
                        end
                    end
                end
                if (trap_target_valid === 1'b1) begin
                    n_checks++;
                    if (exp_q.size() == 0 || exp_q[0].kind != EV_REDIR) begin
                        n_errors++;
                        $display("FAIL redirect unexpected actual target=%h", trap_target);
                        if (exp_q.size() != 0) void'(exp_q.pop_front());
                    end else begin
                        e = exp_q.pop_front();
                        if (trap_target !== e.data || irq_taken !== e.irq) begin
                            n_errors++;
                            $display("FAIL redirect actual target=%h irq_taken=%b required target=%h irq_taken=%b",
                                     trap_target, irq_taken, e.data, e.irq);
                        end
                    end
                end else if (irq_taken === 1'b1) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL irq_taken actual=1 required=0 (no redirect)");
                end
                if (ic_clean === 1'b1) begin
                    n_checks++;
                    if (exp_q.size() == 0 || exp_q[0].kind != EV_FENCE) begin
                        n_errors++;
                        $display("FAIL ic_clean unexpected actual=1 required=0");
                        if (exp_q.size() != 0) void'(exp_q.pop_front());
                    end else begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    endtask

    task automatic preload(logic [31:0] ms, logic [31:0] tvec, logic [31:0] epc);
        pre_ms = ms; pre_tvec = tvec; pre_epc = epc; pre_en = 1'b1;
        ref_ms = ms; ref_tvec = tvec; ref_epc = epc;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    // Reference model computes the expected CSR traffic, then the op is driven and timed.
    task automatic run_op(logic [2:0] code, logic [31:0] pcv, logic [31:0] tv,
                          logic [6:0] mip, int hold, bit drop);
        int lat, n, c;
        bit act, done;
        logic [31:0] t;
        act = 1'b1; lat = 0;
        if (code == TRAP_MRET) begin
            t = ref_ms;
            ref_ms = (t & ~32'h0000_1888) | (((t >> 7) & 32'h1) << 3) | 32'h0000_1880;
            push(EV_WRITE, {20'h0, CSR_MSTATUS}, ref_ms, 1'b0);
            push(EV_REDIR, 32'h0, ref_epc, 1'b0);
            lat = 4; exp_debug = 1'b0;
        end else if (code == TRAP_ECALL || code == TRAP_EBREAK || code == TRAP_MISALIGNED) begin
            c = (code == TRAP_ECALL) ? 11 : (code == TRAP_EBREAK) ? 3 : 0;
            t = (code == TRAP_MISALIGNED) ? tv : (code == TRAP_EBREAK) ? pcv : 32'h0;
            push(EV_WRITE, {20'h0, CSR_MEPC}, pcv, 1'b0);
            push(EV_WRITE, {20'h0, CSR_MCAUSE}, 32'(c), 1'b0);
            push(EV_WRITE, {20'h0, CSR_MTVAL}, t, 1'b0);
            ref_ms = trap_entry_ms(ref_ms);
            ref_epc = pcv;
            push(EV_WRITE, {20'h0, CSR_MSTATUS}, ref_ms, 1'b0);
            if (code == TRAP_EBREAK) begin
                lat = 6; exp_debug = 1'b1;
            end else begin
                push(EV_REDIR, 32'h0, ref_tvec & ~32'h3, 1'b0);
                lat = 7;
            end
        end else if (code == TRAP_FENCEI) begin
            push(EV_FENCE, 32'h0, 32'h0, 1'b0);
            lat = 1;
        end else if (code == TRAP_NONE && ref_ms[3] && pick_irq(mip) >= 0) begin
            c = pick_irq(mip);
            push(EV_WRITE, {20'h0, CSR_MEPC}, pcv, 1'b0);
            push(EV_WRITE, {20'h0, CSR_MCAUSE}, 32'h8000_0000 | 32'(c), 1'b0);
            push(EV_WRITE, {20'h0, CSR_MTVAL}, 32'h0, 1'b0);
            ref_ms = trap_entry_ms(ref_ms);
            ref_epc = pcv;
            push(EV_WRITE, {20'h0, CSR_MSTATUS}, ref_ms, 1'b0);
            t = ref_tvec & ~32'h3;
            if ((ref_tvec & 32'h3) == 32'h1) t = t + 32'(4 * c);
            push(EV_REDIR, 32'h0, t, 1'b1);
            lat = 7;
        end else begin
            act = 1'b0;
        end

        trap_status = code; pc = pcv; trap_value = tv; irq_mip = mip;
        if (act) begin
            n = 0; done = 1'b0;
            while (!done && n < 20) begin
                @(posedge clk); #1;
                n++;
                if (drop && n == 2) irq_mip = 7'h0;
                if (trap_done === 1'b1) done = 1'b1;
            end
            check("latency", 32'(n), 32'(lat));
            repeat (hold) begin @(posedge clk); #1; end
        end else begin
            repeat (4) begin
                @(posedge clk); #1;
                check("idle_trap_done", {31'h0, trap_done}, 32'h1);
            end
        end
        trap_status = TRAP_NONE; irq_mip = 7'h0;
        repeat (2) begin @(posedge clk); #1; end
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        check("debug_mode", {31'h0, debug_mode}, {31'h0, exp_debug});
        check("trap_done_idle", {31'h0, trap_done}, 32'h1);
    endtask

    initial begin
        logic [2:0] code;
        int k;
        rst_n = 1'b0; pre_en = 1'b0; exp_debug = 1'b0;
        trap_status = TRAP_NONE; pc = 32'h0; trap_value = 32'h0; irq_mip = 7'h0;
        pre_ms = 32'h0; pre_tvec = 32'h0; pre_epc = 32'h0;
        fork
            monitor();
        join_none
        repeat (2) begin @(posedge clk); #1; end
        check("rst_trap_done", {31'h0, trap_done}, 32'h1);
        check("rst_target_valid", {31'h0, trap_target_valid}, 32'h0);
        check("rst_target", trap_target, 32'h0);
        check("rst_ic_clean", {31'h0, ic_clean}, 32'h0);
        check("rst_debug", {31'h0, debug_mode}, 32'h0);
        check("rst_irq_taken", {31'h0, irq_taken}, 32'h0);
        check("rst_write_en", {31'h0, bus.csr_trap_write_en}, 32'h0);
        rst_n = 1'b1;

        preload(32'h8, 32'h800, 32'h0);
        run_op(TRAP_ECALL, 32'h100, 32'h0, 7'h0, 1, 1'b0);
        preload(32'h8, 32'h801, 32'h0);
        run_op(TRAP_NONE, 32'h200, 32'h0, 7'b0000010, 0, 1'b1);
        preload(32'h0, 32'h800, 32'h0);
        run_op(TRAP_NONE, 32'h300, 32'h0, 7'b0001111, 0, 1'b0);
        preload(32'h8, 32'h801, 32'h0);
        run_op(TRAP_NONE, 32'h300, 32'h0, 7'b0001111, 1, 1'b0);
        preload(32'h8, 32'h800, 32'h0);
        run_op(TRAP_MISALIGNED, 32'h400, 32'h202, 7'b0000100, 1, 1'b0);
        preload(32'h80, 32'h800, 32'h104);
        run_op(TRAP_MRET, 32'h0, 32'h0, 7'h0, 2, 1'b0);
        preload(32'h8, 32'h800, 32'h0);
        run_op(TRAP_EBREAK, 32'h500, 32'h0, 7'h0, 0, 1'b0);
        run_op(TRAP_MRET, 32'h0, 32'h0, 7'h0, 0, 1'b0);
        run_op(TRAP_FENCEI, 32'h0, 32'h0, 7'h0, 4, 1'b0);

        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 5);
            case (k)
                1:       code = TRAP_ECALL;
                2:       code = TRAP_EBREAK;
                3:       code = TRAP_MISALIGNED;
                4:       code = TRAP_FENCEI;
                5:       code = TRAP_MRET;
                default: code = TRAP_NONE;
            endcase
            preload($urandom | (($urandom_range(0, 3) != 0) ? 32'h8 : 32'h0), $urandom, $urandom);
            run_op(code, $urandom, $urandom, 7'($urandom), $urandom_range(0, 3), 1'($urandom));
        end

        preload(32'h8, 32'h800, 32'h0);
        push(EV_WRITE, {20'h0, CSR_MEPC}, 32'h600, 1'b0);
        push(EV_WRITE, {20'h0, CSR_MCAUSE}, 32'd11, 1'b0);
        push(EV_WRITE, {20'h0, CSR_MTVAL}, 32'h0, 1'b0);
        trap_status = TRAP_ECALL; pc = 32'h600;
        repeat (5) @(posedge clk);
        #1;
        check("pre_abort_addr", {20'h0, bus.csr_trap_address}, {20'h0, CSR_MSTATUS});
        check("pre_abort_we", {31'h0, bus.csr_trap_write_en}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("abort_we", {31'h0, bus.csr_trap_write_en}, 32'h0);
        check("abort_trap_done", {31'h0, trap_done}, 32'h1);
        trap_status = TRAP_NONE;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        check("abort_queue", 32'(exp_q.size()), 32'h0);
        check("abort_trap_done_idle", {31'h0, trap_done}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
